// File: rtl/tcam_pkg.sv
// Shared types and helpers for the ternary CAM.
// Package defaults size the entry struct and the priority-encode helper.
package tcam_pkg;

  localparam int TCAM_DATA_WIDTH = 32;
  localparam int TCAM_ADDR_WIDTH = 5;
  localparam int TCAM_DEPTH      = 1 << TCAM_ADDR_WIDTH;

  typedef enum logic {IDLE, FLUSH} flush_state_e;

  typedef struct packed {
    logic                       valid;
    logic [TCAM_DATA_WIDTH-1:0] mask;
    logic [TCAM_DATA_WIDTH-1:0] data;
  } tcam_entry_t;

  // Scans from the top down so the lowest set bit is written last and wins.
  function automatic logic [TCAM_ADDR_WIDTH:0] prio_enc_lsb(input logic [TCAM_DEPTH-1:0] vec);
    logic [TCAM_ADDR_WIDTH:0] res;
    res = '0;
    for (int i = TCAM_DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) res = {1'b1, TCAM_ADDR_WIDTH'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/tcam_prio_enc.sv
// Lowest-index priority encoder over the CAM match vector.
// With TCAM_MULTIHIT_EN defined it also reports the match population count.
module tcam_prio_enc
  import tcam_pkg::*;
#(
  parameter  int ADDR_WIDTH = TCAM_ADDR_WIDTH,
  localparam int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic [DEPTH-1:0]      match_vec,
  output logic                  hit,
  output logic [ADDR_WIDTH-1:0] addr
`ifdef TCAM_MULTIHIT_EN
  ,
  output logic [ADDR_WIDTH:0]   count
`endif
);

  // Non-default sizes cannot use the package helper, so they get a local scan.
  if (ADDR_WIDTH == TCAM_ADDR_WIDTH) begin : g_pkg_enc
    always_comb {hit, addr} = prio_enc_lsb(match_vec);
  end else begin : g_loop_enc
    always_comb begin
      hit  = 1'b0;
      addr = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (match_vec[i]) begin
          hit  = 1'b1;
          addr = ADDR_WIDTH'(i);
        end
      end
    end
  end

`ifdef TCAM_MULTIHIT_EN
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + (ADDR_WIDTH+1)'(match_vec[i]);
    end
  end
`endif

endmodule

// File: rtl/tcam_core.sv
// Ternary CAM with a 2-cycle pipelined lookup and a one-entry-per-cycle flush sweep.
// Optional multi-hit reporting (rsp_multi, rsp_count) is enabled by TCAM_MULTIHIT_EN.
module tcam_core
  import tcam_pkg::*;
#(
  parameter  int DATA_WIDTH = TCAM_DATA_WIDTH,
  parameter  int ADDR_WIDTH = TCAM_ADDR_WIDTH,
  localparam int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  input  logic                  wr_valid,
  input  logic                  flush_req,
  output logic                  flush_busy,
  input  logic                  lk_valid,
  output logic                  lk_ready,
  input  logic [DATA_WIDTH-1:0] lk_data,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic [ADDR_WIDTH-1:0] rsp_addr
`ifdef TCAM_MULTIHIT_EN
  ,
  output logic                  rsp_multi,
  output logic [ADDR_WIDTH:0]   rsp_count
`endif
);

  logic [DEPTH-1:0]      ent_valid;
  logic [DATA_WIDTH-1:0] ent_data [DEPTH];
  logic [DATA_WIDTH-1:0] ent_mask [DEPTH];

  flush_state_e          state, state_next;
  logic [ADDR_WIDTH-1:0] flush_ptr;

  logic                  lk_accept, wr_accept;
  logic [DEPTH-1:0]      match_vec, s1_match;
  logic                  s1_valid;
  logic                  enc_hit;
  logic [ADDR_WIDTH-1:0] enc_addr;
`ifdef TCAM_MULTIHIT_EN
  logic [ADDR_WIDTH:0]   enc_count;
`endif

  assign flush_busy = (state == FLUSH);
  assign lk_ready   = !flush_busy;
  assign lk_accept  = lk_valid && lk_ready;
  assign wr_accept  = wr_en && !flush_busy;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (flush_req) state_next = FLUSH;
      FLUSH:   if (&flush_ptr) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The pointer parks at 0 in IDLE and wraps back to 0 after the last entry.
  always_ff @(posedge clk) begin
    if (reset || state == IDLE) flush_ptr <= '0;
    else                        flush_ptr <= flush_ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)          ent_valid            <= '0;
    else if (flush_busy) ent_valid[flush_ptr] <= 1'b0;
    else if (wr_accept) ent_valid[wr_addr]   <= wr_valid;
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      ent_data[wr_addr] <= wr_data;
      ent_mask[wr_addr] <= wr_mask;
    end
  end

  // Compares against the table as it stood before this edge's write lands.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = ent_valid[i] && (((ent_data[i] ^ lk_data) & ~ent_mask[i]) == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) s1_valid <= 1'b0;
    else       s1_valid <= lk_accept;
  end

  always_ff @(posedge clk) begin
    if (lk_accept) s1_match <= match_vec;
  end

  tcam_prio_enc #(.ADDR_WIDTH(ADDR_WIDTH)) u_prio_enc (
    .match_vec (s1_match),
    .hit       (enc_hit),
    .addr      (enc_addr)
`ifdef TCAM_MULTIHIT_EN
    ,
    .count     (enc_count)
`endif
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_addr  <= '0;
`ifdef TCAM_MULTIHIT_EN
      rsp_multi <= 1'b0;
      rsp_count <= '0;
`endif
    end else begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_hit   <= enc_hit;
        rsp_addr  <= enc_addr;
`ifdef TCAM_MULTIHIT_EN
        rsp_multi <= (enc_count > (ADDR_WIDTH+1)'(1));
        rsp_count <= enc_count;
`endif
      end
    end
  end

endmodule

// File: doc/tcam_core.md
Name: tcam_core

Overview:
- Parametrised ternary CAM for associative lookup.
- Each entry stores data, a per-bit don't-care mask and a valid bit.
- Lookups use a valid/ready request and a fixed 2-cycle pipelined response that returns the lowest-index matching entry.
- A sequential flush engine invalidates the table one entry per cycle.
- Successor to the single-cycle binary CAM; sits in the classification path between header parse and action lookup.

Parameters:
- DATA_WIDTH, 32, key/entry width in bits.
- ADDR_WIDTH, 5, entry index width; DEPTH = 2**ADDR_WIDTH entries.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe for entry wr_addr.
- wr_addr  input  ADDR_WIDTH  entry index to write.
- wr_data  input  DATA_WIDTH  entry key.
- wr_mask  input  DATA_WIDTH  per-bit don't-care; 1 = bit ignored in compare.
- wr_valid  input  1  valid bit stored with the entry; 0 invalidates it.
- flush_req  input  1  pulse: start invalidate-all sweep.
- flush_busy  output  1  high while the sweep runs.
- lk_valid  input  1  lookup request valid.
- lk_ready  output  1  lookup request accepted when lk_valid && lk_ready.
- lk_data  input  DATA_WIDTH  search key.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_hit  output  1  at least one entry matched.
- rsp_addr  output  ADDR_WIDTH  lowest matching index; 0 when rsp_hit=0.

Behaviour:
- Reset (synchronous, active-high):
  - all entry valid bits = 0; data and mask contents are don't-care.
  - FSM = IDLE; flush_busy = 0; rsp_valid = 0, rsp_hit = 0, rsp_addr = 0.
  - pipeline valids cleared, so any in-flight lookup is dropped with no response.
- Match rule:
  - entry i matches when valid[i] && (((entry_data[i] ^ lk_data) & ~entry_mask[i]) == 0).
  - An all-ones mask matches any key.
- Write:
  - wr_en high: {wr_valid, wr_mask, wr_data} is stored at wr_addr on that clock edge.
  - Writes are ignored while flush_busy = 1.
- Lookup pipeline:
  - lk_ready = !flush_busy (combinational from the FSM state register).
  - S1: the cycle after acceptance, registers the DEPTH-bit match vector.
  - S2: priority-encodes the match vector (lowest index wins) into rsp_hit/rsp_addr and asserts rsp_valid.
  - A request accepted in cycle t gives rsp_valid = 1 in cycle t+2. Throughput is 1 lookup/cycle; there is no output backpressure.
  - rsp_hit and rsp_addr hold their last values when rsp_valid = 0.
- Read/write hazard:
  - A lookup accepted in the same cycle as a write to the matching entry sees the OLD contents.
  - A lookup accepted in the following cycle sees the new contents.
- Flush FSM (states IDLE, FLUSH):
  - IDLE -> FLUSH on flush_req: ptr = 0, flush_busy = 1 from the next cycle.
  - FLUSH: clear valid[ptr], ptr++. After clearing DEPTH-1, return to IDLE.
  - flush_busy is high for exactly DEPTH cycles.
  - flush_req while in FLUSH is ignored (no restart, no queueing).
  - Lookups already in S1/S2 when the flush starts complete normally with their pre-flush compare results.
  - Reset during FLUSH: immediately IDLE with the table invalid.
- Simultaneous events:
  - flush_req and wr_en in the same IDLE cycle: the write is performed, then the sweep clears it.
  - flush_req and lk_valid in the same IDLE cycle: the lookup is accepted, because lk_ready is still 1 in that cycle.

Optional Feature:
- Macro TCAM_MULTIHIT_EN.
- Defined:
  - adds output rsp_multi (1 bit), high with rsp_valid when 2 or more entries matched. Reset value 0.
  - adds output rsp_count (ADDR_WIDTH+1 bits), the population count of the match vector, computed in S2.
- Undefined: these ports and their logic are absent; everything else is identical.

Decomposition:
- Package tcam_pkg holds:
  - flush_state_e enum {IDLE, FLUSH};
  - the tcam_entry_t packed struct {valid, mask, data}, parametrised via package-level localparam defaults;
  - function prio_enc_lsb returning {hit, addr} for a match vector.
- Sub-module tcam_prio_enc (DEPTH-wide lowest-index priority encoder plus optional popcount), instantiated in S2.

Test Plan:
- Exact match: write addr 3 = 0xDEADBEEF, mask 0, valid 1; lookup 0xDEADBEEF -> two cycles later rsp_valid=1, rsp_hit=1, rsp_addr=3.
- Ternary priority:
  - write addr 7 = 0x12340000 with mask 0x0000FFFF, and addr 2 = 0x12345678 with mask 0.
  - lookup 0x12345678 -> rsp_addr=2; with TCAM_MULTIHIT_EN, rsp_multi=1 and rsp_count=2.
  - lookup 0x1234ABCD -> rsp_addr=7.
- Miss and invalidate: write addr 3 with wr_valid=0, then lookup 0xDEADBEEF -> rsp_hit=0, rsp_addr=0.
- Same-cycle hazard:
  - write addr 5 = 0xAAAA0000 in the same cycle as a lookup of 0xAAAA0000 -> miss.
  - the lookup in the next cycle -> hit at addr 5.
- Flush:
  - fill all 32 entries, then pulse flush_req -> flush_busy high for exactly 32 cycles and lk_ready=0.
  - a write issued mid-flush is ignored.
  - after the flush, a lookup of any previously stored key -> rsp_hit=0.
- Reset mid-pipeline: accept back-to-back lookups, then assert reset on cycle t+1 -> no rsp_valid follows, and all entries read invalid.
